seq010_rr_scheduler: RTL
========================

// Module: seq010_rr_scheduler
// PURPOSE
//  Shares one 010-sequence detector (clk, rst, x -> y, users_count) between N requesters.
//  Round-robin arbitration grants one requester at a time, clears the detector and
//  serialises the granted frame into it MSB-first, one bit per clock.
//  Captures the final match count and returns it with a per-requester done pulse.
//  Also counts det_y pulses internally as a cross-check.
// PARAMETERS
//  N_REQ    4   number of requesters
//  FRAME_W  16  bits per frame, shifted MSB first
//  COUNT_W  10  width of detector users_count and of result_count
// PORTS
//  clk              in   1               system clock, all logic on posedge
//  rst              in   1               synchronous active-high reset
//  req              in   N_REQ           level request; held with frame stable until done
//  frame_data       in   N_REQ*FRAME_W   frame of req[i] at [i*FRAME_W +: FRAME_W]
//  done             out  N_REQ           one-hot, 1-cycle pulse: frame of req[i] finished
//  grant_id         out  $clog2(N_REQ)   index of requester currently served
//  busy             out  1               high from grant until done inclusive
//  result_count     out  COUNT_W         match count of last frame; valid with done
//  mismatch         out  1               with done: det_users_count != internal y count
//  det_rst          out  1               reset to shared detector
//  det_x            out  1               serial bit to detector
//  det_y            in   1               detector match flag, high while detector is in STORE
//  det_users_count  in   COUNT_W         detector running match count
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   state=IDLE, rr pointer=0, done=0, busy=0, grant_id=0, result_count=0, mismatch=0.
//   det_rst=1 while rst is high; det_x=1.
//  FSM states: IDLE, CLEAR, SHIFT, DRAIN, REPORT.
//   IDLE: if any req, grant first set bit at or after the rr pointer (wrapping). Latch
//    grant_id and the frame into the shift register. busy=1. Go to CLEAR.
//   CLEAR: det_rst=1 for exactly 1 cycle; internal y counter cleared. Go to SHIFT.
//   SHIFT: FRAME_W cycles; det_x = shreg[FRAME_W-1], shift left each cycle.
//    Bit index counter rolls FRAME_W-1 -> DRAIN.
//   DRAIN: 2 cycles with det_x=1. A '1' never creates a new STORE, so the final count
//    increment and y pulse land here. On the edge leaving the 2nd DRAIN cycle:
//    result_count <= det_users_count; mismatch <= (det_users_count != y count).
//   REPORT: done[grant_id]=1 for 1 cycle; rr pointer <= grant_id+1 (mod N_REQ). Go to IDLE.
//  det_rst=0 and det_x=1 in all states except the cases above.
//  Internal y counter: COUNT_W bits, +1 each cycle det_y=1 in SHIFT or DRAIN; wraps mod 2^COUNT_W.
//  Latency: grant to done = 1 (CLEAR) + FRAME_W + 2 + 1 cycles; default 20.
//   One IDLE cycle separates consecutive frames.
//  req changes after grant are ignored until REPORT; a dropped req still completes and pulses done.
//  req still high in the IDLE after done counts as a new request (fairness via rr pointer).
//  Simultaneous requests: lowest index at or above the pointer wins; the others wait.
//  rst mid-frame: abort immediately, no done pulse, detector reset, pointer back to 0.
//  result_count/mismatch hold their values until the next REPORT.
// TESTING
//  1 FRAME_W=8, req=0001, frame0=8'b0100_1000 -> det_x seq 0,1,0,0,1,0,0,0; done[0] at grant+12;
//    result_count=2; mismatch=0
//  2 req=1111 held, all frames 8'hFF -> done order 0,1,2,3,0 (one per 13 cycles);
//    result_count=0 each
//  3 rr pointer=2, req=0101 same cycle -> grant_id=2 first, then 0
//  4 rst high during SHIFT of req1 -> done stays 0, det_rst=1, state IDLE next cycle;
//    req1 regranted, correct count
//  5 req0 dropped during SHIFT -> done[0] still pulses; no regrant of req0
//  6 forced det_users_count stuck at 0, frame with 2 matches -> result_count=0, mismatch=1

Source files
------------

// File: rtl/seq010_rr_scheduler.sv
// ---------------------------------------------------------------------------
// seq010_rr_scheduler
//   Time-shares one external "010" sequence detector between N_REQ requesters.
//   A round-robin arbiter picks one requester, the detector is cleared, the
//   granted frame is shifted into it MSB first, two idle '1' bits let the last
//   match settle, and the detector's final match count is returned together
//   with a one-cycle done pulse for that requester. Pulses on det_y are also
//   counted locally so a disagreeing detector count can be flagged.
//
// Ports
//   clk             : system clock, rising edge
//   rst             : synchronous active-high reset
//   req[N_REQ]      : level requests, held with frame stable until done
//   frame_data      : frame of requester i at [i*FRAME_W +: FRAME_W]
//   done[N_REQ]     : one-hot single-cycle completion pulse
//   grant_id        : index of the requester being served
//   busy            : high from the cycle after grant through the done cycle
//   result_count    : detector match count of the last completed frame
//   mismatch        : detector count disagreed with the local det_y count
//   det_rst         : reset to the shared detector
//   det_x           : serial bit to the shared detector
//   det_y           : detector match flag
//   det_users_count : detector running match count
// ---------------------------------------------------------------------------
module seq010_rr_scheduler #(
  parameter int N_REQ   = 4,
  parameter int FRAME_W = 16,
  parameter int COUNT_W = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*FRAME_W-1:0]    frame_data,
  output logic [N_REQ-1:0]            done,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic                        busy,
  output logic [COUNT_W-1:0]          result_count,
  output logic                        mismatch,
  output logic                        det_rst,
  output logic                        det_x,
  input  logic                        det_y,
  input  logic [COUNT_W-1:0]          det_users_count
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int BIT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SHIFT  = 3'd2,
    S_DRAIN  = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  state_t               state_q,    state_d;
  logic [ID_W-1:0]      ptr_q,      ptr_d;
  logic [ID_W-1:0]      grant_q,    grant_d;
  logic [COUNT_W-1:0]   result_q,   result_d;
  logic                 mismatch_q, mismatch_d;
  logic [FRAME_W-1:0]   shreg_q,    shreg_d;
  logic [BIT_W-1:0]     bit_q,      bit_d;
  logic                 drain_q,    drain_d;
  logic [COUNT_W-1:0]   ycnt_q,     ycnt_d;

  // Round-robin pick: first requester at or after the pointer, wrapping.
  logic                 sel_found;
  logic [ID_W-1:0]      sel_idx;
  logic [ID_W-1:0]      cand;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ID_W'((int'(ptr_q) + i) % N_REQ);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // ---- state register ----
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    bit_q   <= bit_d;
    drain_q <= drain_d;
    ycnt_q  <= ycnt_d;
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      result_q   <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      result_q   <= result_d;
      mismatch_q <= mismatch_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    result_d   = result_q;
    mismatch_d = mismatch_q;
    shreg_d    = shreg_q;
    bit_d      = bit_q;
    drain_d    = drain_q;
    ycnt_d     = ycnt_q;

    if ((state_q == S_SHIFT || state_q == S_DRAIN) && det_y) begin
      ycnt_d = ycnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          grant_d = sel_idx;
          shreg_d = frame_data[int'(sel_idx)*FRAME_W +: FRAME_W];
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        ycnt_d  = '0;
        bit_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        shreg_d = shreg_q << 1;
        if (bit_q == BIT_W'(FRAME_W - 1)) begin
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // The last match's count increment and y pulse have landed by the
        // second drain cycle, so both counts are final at this edge.
        if (drain_q) begin
          result_d   = det_users_count;
          mismatch_d = (det_users_count != ycnt_q);
          state_d    = S_REPORT;
        end else begin
          drain_d = 1'b1;
        end
      end
      S_REPORT: begin
        ptr_d   = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- outputs ----
  always_comb begin
    done = '0;
    if (!rst && state_q == S_REPORT) begin
      done[grant_q] = 1'b1;
    end
    busy         = (state_q != S_IDLE);
    grant_id     = grant_q;
    result_count = result_q;
    mismatch     = mismatch_q;
    det_rst      = rst || (state_q == S_CLEAR);
    det_x        = (!rst && state_q == S_SHIFT) ? shreg_q[FRAME_W-1] : 1'b1;
  end

endmodule
